lives_ctrl: RTL and testbench
=============================

Name: lives_ctrl

Overview:
- Game-level lives manager that owns the player's life count.
- Its `lives` output drives the 3-bit `len` input of the on-screen hearts display generator.
- Consumes collision, extra-life and frame-tick pulses from game logic.
- Sequences death animation, respawn, post-respawn invulnerability and game over.

Parameters:
- INIT_LIVES, 3: lives loaded on start_game; 1..MAX_LIVES.
- MAX_LIVES, 5: saturation ceiling for extra lives; ≤7 (3-bit count).
- DEATH_FRAMES, 90: frame ticks spent in DYING before respawn or game over; ≥1.
- INVULN_FRAMES, 120: frame ticks after respawn during which hits are ignored; 0 disables.

Ports:
- clk  input  1  system clock.
- resetN  input  1  asynchronous, active-low reset.
- start_game  input  1  one-cycle pulse; (re)starts a game from any state.
- pacman_hit  input  1  one-cycle pulse; ghost collision.
- extra_life  input  1  one-cycle pulse from score logic; award one life.
- frame_tick  input  1  one-cycle pulse per video frame.
- lives  output  3  current life count; feeds the hearts generator `len`.
- lives_disp  output  3  display count (see Optional Feature); equals lives when the feature is off.
- dying  output  1  high while in DYING; freezes movers and selects the death sprite.
- respawn  output  1  one-cycle pulse when leaving DYING with lives>0; repositions actors.
- invuln  output  1  high while the invulnerability counter is nonzero.
- game_over  output  1  high in GAME_OVER.

Behaviour:
- Reset is clk/resetN, asynchronous, active-low. All outputs and counters are registered and clear to 0; state = IDLE.
- Outputs change 1 cycle after the causing input edge.

States:
- IDLE: waits for start_game.
- PLAY: normal play.
- DYING: death animation in progress.
- GAME_OVER: holds until start_game.

Transitions:
- start_game (any state, highest priority): lives←INIT_LIVES, frame counter←0, invuln counter←0, state←PLAY. Other inputs are ignored that cycle.
- PLAY & pacman_hit & invuln counter==0: state←DYING, frame counter←0.
- pacman_hit in IDLE, DYING, GAME_OVER, or with invuln counter>0: ignored.
- DYING: frame counter increments on frame_tick. When a frame_tick arrives with counter==DEATH_FRAMES-1:
  - lives←lives-1.
  - If the old lives>1: respawn pulse, invuln counter←INVULN_FRAMES, state←PLAY.
  - Otherwise: state←GAME_OVER, lives=0.
- Invuln counter decrements on frame_tick when nonzero, in PLAY only.

extra_life:
- Accepted in PLAY and DYING: lives←min(lives+1, MAX_LIVES). Silently dropped at MAX_LIVES.
- Ignored in IDLE and GAME_OVER.

Simultaneous events:
- extra_life same cycle as DYING expiry: net lives = lives-1+1. The respawn/game-over decision uses the net value; net 0 → GAME_OVER.
- extra_life same cycle as an accepted hit: both apply (increment, then enter DYING).
- frame_tick same cycle as hit: the hit takes effect; the tick is not counted in DYING.

Other rules:
- Lives never underflows below 0 or exceeds MAX_LIVES. Arithmetic is 3-bit unsigned with explicit saturation checks.
- Reset mid-DYING: immediate return to IDLE; no respawn pulse.

Optional Feature:
- Macro: LIVES_BLINK_EN.
- Defined: during DYING, lives_disp alternates between lives and lives-1 every 8 frame_ticks, starting with lives-1 on DYING entry. A 3-bit blink counter is added, and the lost heart flashes on screen.
- Undefined: lives_disp is a direct copy of lives; no blink logic is synthesised.

Decomposition:
- Shared game package holds:
  - typedef enum lives_state_t {IDLE, PLAY, DYING, GAME_OVER};
  - LIVES_W = 3;
  - default INIT_LIVES/MAX_LIVES constants, reused by the score and HUD blocks.
- One natural sub-module: frame_down_counter, a loadable frame_tick-gated down counter with a zero flag. It is instantiated twice, for the death timer and the invulnerability timer.

Test Plan:
- Reset then start_game → lives=3, state PLAY, game_over=0, dying=0.
- PLAY, hit, then 90 frame_ticks (DEATH_FRAMES=90) → dying=1 during the animation; respawn pulse one cycle after the 90th tick; lives=2, invuln=1 for 120 ticks.
- Hit during invuln → no DYING. Hit after invuln expires → DYING entered.
- Lives=1, hit, 90 ticks → lives=0, game_over=1, no respawn pulse. Then hit or extra_life → no change. Then start_game → lives=3, PLAY.
- Lives=5, extra_life ×2 → lives stays 5. Lives=1 in DYING with extra_life coincident with expiry → respawn, lives=1, no game over.
- With LIVES_BLINK_EN, lives=3, hit → lives_disp=2 for ticks 0-7, 3 for ticks 8-15, …. Without the macro → lives_disp==lives throughout.

Source files
------------

// File: rtl/lives_ctrl_pkg.sv
// lives_ctrl_pkg: shared game types and lives defaults used by lives, score and HUD blocks
package lives_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, PLAY, DYING, GAME_OVER} lives_state_t;
  localparam int LIVES_W = 3;
  localparam int DEF_INIT_LIVES = 3;
  localparam int DEF_MAX_LIVES = 5;
  function automatic logic [LIVES_W-1:0] sat_inc(input logic [LIVES_W-1:0] l, input logic [LIVES_W-1:0] m);
    return (l < m) ? l + LIVES_W'(1) : l;
  endfunction
endpackage

// File: rtl/lives_ctrl_frame_down_counter.sv
// frame_down_counter: loadable frame_tick-gated down counter that stops at zero and flags it
module frame_down_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         resetN,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic         zero
);
  logic [W-1:0] cnt;
  // load wins over counting; counting only happens on gated ticks while nonzero
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (tick && cnt != '0) cnt <= cnt - W'(1);
  assign zero = (cnt == '0);
endmodule

// File: rtl/lives_ctrl.sv
// lives_ctrl: player life count, death animation timing, respawn, invulnerability and game over; LIVES_BLINK_EN adds a flashing lost heart on lives_disp
module lives_ctrl
  import lives_ctrl_pkg::*;
#(
  parameter int INIT_LIVES = DEF_INIT_LIVES,
  parameter int MAX_LIVES = DEF_MAX_LIVES,
  parameter int DEATH_FRAMES = 90,
  parameter int INVULN_FRAMES = 120
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               start_game,
  input  logic               pacman_hit,
  input  logic               extra_life,
  input  logic               frame_tick,
  output logic [LIVES_W-1:0] lives,
  output logic [LIVES_W-1:0] lives_disp,
  output logic               dying,
  output logic               respawn,
  output logic               invuln,
  output logic               game_over
);
  localparam int DW = DEATH_FRAMES > 1 ? $clog2(DEATH_FRAMES) : 1;
  localparam int IW = INVULN_FRAMES > 0 ? $clog2(INVULN_FRAMES + 1) : 1;
  lives_state_t state, state_n;
  logic [LIVES_W-1:0] lives_n;
  logic respawn_n, hit_ok, expire, death_zero, inv_zero;
  assign hit_ok = !start_game && state == PLAY && pacman_hit && inv_zero;
  assign expire = !start_game && state == DYING && frame_tick && death_zero;
  // death timer holds DEATH_FRAMES-1 on entry; the tick that finds it at zero ends the animation
  frame_down_counter #(.W(DW)) u_death (
    .clk(clk),
    .resetN(resetN),
    .load(start_game || hit_ok),
    .load_val(start_game ? '0 : DW'(DEATH_FRAMES - 1)),
    .tick(frame_tick && state == DYING),
    .zero(death_zero)
  );
  frame_down_counter #(.W(IW)) u_invuln (
    .clk(clk),
    .resetN(resetN),
    .load(start_game || (expire && lives_n != '0)),
    .load_val(start_game ? '0 : IW'(INVULN_FRAMES)),
    .tick(frame_tick && state == PLAY),
    .zero(inv_zero)
  );
  // state, lives and the respawn pulse are all registered
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      state <= IDLE;
      lives <= '0;
      respawn <= 1'b0;
    end else begin
      state <= state_n;
      lives <= lives_n;
      respawn <= respawn_n;
    end
  // extra life applies first so the expiry decision sees the net count
  always_comb begin
    state_n = state;
    lives_n = lives;
    respawn_n = 1'b0;
    if (start_game) begin
      state_n = PLAY;
      lives_n = LIVES_W'(INIT_LIVES);
    end else begin
      if (extra_life && (state == PLAY || state == DYING)) lives_n = sat_inc(lives, LIVES_W'(MAX_LIVES));
      if (hit_ok) state_n = DYING;
      if (expire) begin
        lives_n = (lives_n != '0) ? lives_n - LIVES_W'(1) : '0;
        state_n = (lives_n != '0) ? PLAY : GAME_OVER;
        respawn_n = (lives_n != '0);
      end
    end
  end
  assign dying = (state == DYING);
  assign game_over = (state == GAME_OVER);
  assign invuln = !inv_zero;
`ifdef LIVES_BLINK_EN
  logic [2:0] blink_cnt;
  logic blink_ph;
  // phase flips every 8 death ticks, starting on the reduced count
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      blink_cnt <= '0;
      blink_ph <= 1'b0;
    end else if (hit_ok) begin
      blink_cnt <= '0;
      blink_ph <= 1'b1;
    end else if (state == DYING && frame_tick) begin
      blink_cnt <= blink_cnt + 3'd1;
      blink_ph <= (blink_cnt == 3'd7) ? !blink_ph : blink_ph;
    end
  assign lives_disp = (dying && blink_ph && lives != '0) ? lives - LIVES_W'(1) : lives;
`else
  assign lives_disp = lives;
`endif
endmodule

// File: tb/tb_lives_ctrl.sv
// tb_lives_ctrl: directed self-checking bench for lives_ctrl
module tb_lives_ctrl;
  logic clk = 1'b0, resetN = 1'b0;
  logic start_game = 1'b0, pacman_hit = 1'b0, extra_life = 1'b0, frame_tick = 1'b0;
  logic [2:0] lives, lives_disp;
  logic dying, respawn, invuln, game_over;
  int tests = 0, fails = 0;
  wire [6:0] st = {lives, dying, respawn, invuln, game_over};

  lives_ctrl dut (
    .clk(clk), .resetN(resetN), .start_game(start_game), .pacman_hit(pacman_hit),
    .extra_life(extra_life), .frame_tick(frame_tick), .lives(lives), .lives_disp(lives_disp),
    .dying(dying), .respawn(respawn), .invuln(invuln), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic pulse(input logic s, input logic h, input logic e, input logic t);
    @(negedge clk);
    {start_game, pacman_hit, extra_life, frame_tick} = {s, h, e, t};
    @(negedge clk);
    {start_game, pacman_hit, extra_life, frame_tick} = 4'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) pulse(0, 0, 0, 1);
  endtask

  task automatic test_reset;
    resetN = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if (st !== 7'b000_0000) begin fails++; $display("FAIL reset_state: got %b want %b", st, 7'b000_0000); end
    tests++; if (lives_disp !== 3'd0) begin fails++; $display("FAIL reset_disp: got %0d want 0", lives_disp); end
    resetN = 1'b1;
    pulse(0, 1, 1, 1);
    tests++; if (st !== 7'b000_0000) begin fails++; $display("FAIL idle_ignores: got %b want %b", st, 7'b000_0000); end
  endtask

  task automatic test_start;
    pulse(1, 0, 0, 0);
    tests++; if (st !== 7'b011_0000) begin fails++; $display("FAIL start: got %b want %b", st, 7'b011_0000); end
  endtask

  task automatic test_death_respawn;
    pulse(0, 1, 0, 0);
    tests++; if (st !== 7'b011_1000) begin fails++; $display("FAIL hit_enter_dying: got %b want %b", st, 7'b011_1000); end
    ticks(89);
    tests++; if (st !== 7'b011_1000) begin fails++; $display("FAIL dying_89: got %b want %b", st, 7'b011_1000); end
    ticks(1);
    tests++; if (st !== 7'b010_0110) begin fails++; $display("FAIL respawn: got %b want %b", st, 7'b010_0110); end
    @(negedge clk);
    tests++; if (st !== 7'b010_0010) begin fails++; $display("FAIL respawn_one_cycle: got %b want %b", st, 7'b010_0010); end
  endtask

  task automatic test_invuln;
    pulse(0, 1, 0, 0);
    tests++; if (st !== 7'b010_0010) begin fails++; $display("FAIL hit_during_invuln: got %b want %b", st, 7'b010_0010); end
    ticks(119);
    tests++; if (st !== 7'b010_0010) begin fails++; $display("FAIL invuln_119: got %b want %b", st, 7'b010_0010); end
    ticks(1);
    tests++; if (st !== 7'b010_0000) begin fails++; $display("FAIL invuln_expire: got %b want %b", st, 7'b010_0000); end
    pulse(0, 1, 0, 0);
    tests++; if (st !== 7'b010_1000) begin fails++; $display("FAIL hit_after_invuln: got %b want %b", st, 7'b010_1000); end
  endtask

  task automatic test_extra_at_expiry;
    ticks(90);
    tests++; if (st !== 7'b001_0110) begin fails++; $display("FAIL second_respawn: got %b want %b", st, 7'b001_0110); end
    ticks(120);
    pulse(0, 1, 0, 0);
    ticks(89);
    pulse(0, 0, 1, 1);
    tests++; if (st !== 7'b001_0110) begin fails++; $display("FAIL extra_at_expiry: got %b want %b", st, 7'b001_0110); end
    ticks(120);
    tests++; if (st !== 7'b001_0000) begin fails++; $display("FAIL play_one_life: got %b want %b", st, 7'b001_0000); end
  endtask

  task automatic test_game_over;
    pulse(0, 1, 0, 0);
    ticks(90);
    tests++; if (st !== 7'b000_0001) begin fails++; $display("FAIL game_over: got %b want %b", st, 7'b000_0001); end
    pulse(0, 1, 0, 0);
    pulse(0, 0, 1, 0);
    tests++; if (st !== 7'b000_0001) begin fails++; $display("FAIL game_over_hold: got %b want %b", st, 7'b000_0001); end
    pulse(1, 0, 0, 0);
    tests++; if (st !== 7'b011_0000) begin fails++; $display("FAIL restart: got %b want %b", st, 7'b011_0000); end
  endtask

  task automatic test_hit_with_tick;
    pulse(0, 1, 0, 1);
    ticks(89);
    tests++; if (st !== 7'b011_1000) begin fails++; $display("FAIL hit_tick_not_counted: got %b want %b", st, 7'b011_1000); end
    ticks(1);
    tests++; if (st !== 7'b010_0110) begin fails++; $display("FAIL hit_tick_respawn: got %b want %b", st, 7'b010_0110); end
  endtask

  task automatic test_max_lives;
    pulse(1, 0, 0, 0);
    pulse(0, 0, 1, 0);
    pulse(0, 0, 1, 0);
    tests++; if (st !== 7'b101_0000) begin fails++; $display("FAIL extra_to_max: got %b want %b", st, 7'b101_0000); end
    pulse(0, 0, 1, 0);
    pulse(0, 0, 1, 0);
    tests++; if (st !== 7'b101_0000) begin fails++; $display("FAIL extra_saturate: got %b want %b", st, 7'b101_0000); end
  endtask

  task automatic test_disp;
    pulse(1, 0, 0, 0);
    pulse(0, 1, 0, 0);
`ifdef LIVES_BLINK_EN
    tests++; if (lives_disp !== 3'd2) begin fails++; $display("FAIL blink_entry: got %0d want 2", lives_disp); end
    ticks(7);
    tests++; if (lives_disp !== 3'd2) begin fails++; $display("FAIL blink_t7: got %0d want 2", lives_disp); end
    ticks(1);
    tests++; if (lives_disp !== 3'd3) begin fails++; $display("FAIL blink_t8: got %0d want 3", lives_disp); end
    ticks(8);
    tests++; if (lives_disp !== 3'd2) begin fails++; $display("FAIL blink_t16: got %0d want 2", lives_disp); end
`else
    tests++; if (lives_disp !== 3'd3) begin fails++; $display("FAIL disp_entry: got %0d want 3", lives_disp); end
    ticks(8);
    tests++; if (lives_disp !== 3'd3) begin fails++; $display("FAIL disp_t8: got %0d want 3", lives_disp); end
`endif
  endtask

  task automatic test_reset_mid_dying;
    pulse(1, 0, 0, 0);
    pulse(0, 1, 1, 0);
    tests++; if (st !== 7'b100_1000) begin fails++; $display("FAIL hit_plus_extra: got %b want %b", st, 7'b100_1000); end
    ticks(10);
    @(negedge clk);
    resetN = 1'b0;
    #1;
    tests++; if (st !== 7'b000_0000) begin fails++; $display("FAIL async_reset_dying: got %b want %b", st, 7'b000_0000); end
    @(negedge clk);
    resetN = 1'b1;
    repeat (2) @(negedge clk);
    tests++; if (st !== 7'b000_0000) begin fails++; $display("FAIL idle_after_reset: got %b want %b", st, 7'b000_0000); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_death_respawn();
    test_invuln();
    test_extra_at_expiry();
    test_game_over();
    test_hit_with_tick();
    test_max_lives();
    test_disp();
    test_reset_mid_dying();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
